// File: rtl/brs_pkg.sv
// Shared types and defaults for the brs UART receiver.
package brs_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned DATA_W           = 8;
    localparam int unsigned IDX_W            = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } brs_state_e;

endpackage

// File: rtl/brs_sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module brs_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/brs_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, single-entry holding register,
// frame-error pulse and sticky overrun flag.
module brs_uart_rx
    import brs_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic rxs;

    brs_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rxs)
    );

    brs_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              fe_q, fe_d;
    logic              ov_q, ov_d;
    logic              busy_q, busy_d;
    logic              deliver;
    logic              cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Next-state, bit timing and holding-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = ov_q;
        deliver = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxs) begin
                    state_d = ST_DATA;
                    cnt_d   = FULL_LOAD;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = FULL_LOAD;
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    deliver = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fe_d    = 1'b1;
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // A full register that is not being drained in this cycle drops the byte.
        if (deliver) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_brs_uart_rx.sv
// Scoreboard bench for brs_uart_rx: directed frames, expected bytes queued, monitor pops on handshake.
module tb_brs_uart_rx;

    localparam int unsigned C   = 16;
    localparam int unsigned LAT = 2 + C / 2 + 9 * C + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    brs_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         fe_cnt = 0;
    int         rise_cyc = -1;
    int         t_fall = 0;
    int         fe0;
    logic       valid_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count frame errors, timestamp valid rises, check bytes on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err_o) fe_cnt++;
            if (valid_o && !valid_prev) rise_cyc = cyc;
            if (valid_o && ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL deliver: unexpected byte %02h (none expected)", data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e) begin
                        bad++;
                        $display("FAIL deliver: got %02h want %02h", data_o, e);
                    end
                end
            end
        end
        valid_prev = valid_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level (left on the line).
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_i   = 1'b0;
        t_fall = cyc;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(C);
        end
        rx_i = stop;
        tick(C);
    endtask

    initial begin
        rst     = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        tick(3);
        chk("rst_data",  32'(data_o),      32'h0);
        chk("rst_valid", 32'(valid_o),     32'h0);
        chk("rst_fe",    32'(frame_err_o), 32'h0);
        chk("rst_ov",    32'(overrun_o),   32'h0);
        chk("rst_busy",  32'(busy_o),      32'h0);
        rst = 1'b0;
        tick(5);

        // Single good byte with consumer ready.
        fe0 = fe_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(5);
        chk("a5_latency", 32'(rise_cyc - t_fall), 32'(LAT));
        chk("a5_fe",      32'(fe_cnt - fe0),      32'h0);
        chk("a5_ov",      32'(overrun_o),         32'h0);
        chk("a5_valid",   32'(valid_o),           32'h0);

        // Short low glitch rejected at the start-bit sample.
        fe0  = fe_cnt;
        rx_i = 1'b0;
        tick(4);
        chk("glitch_busy_hi", 32'(busy_o), 32'h1);
        rx_i = 1'b1;
        tick(8);
        chk("glitch_busy_lo", 32'(busy_o),        32'h0);
        chk("glitch_valid",   32'(valid_o),       32'h0);
        chk("glitch_fe",      32'(fe_cnt - fe0),  32'h0);
        tick(5);

        // Bad stop bit followed by a held-low break.
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        tick(40);
        chk("brk_busy_hi", 32'(busy_o),  32'h1);
        chk("brk_valid",   32'(valid_o), 32'h0);
        rx_i = 1'b1;
        tick(6);
        chk("brk_busy_lo", 32'(busy_o),       32'h0);
        chk("brk_fe",      32'(fe_cnt - fe0), 32'h1);

        // Two bytes with consumer stalled: second one overruns.
        ready_i = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(5);
        chk("ovr_data",  32'(data_o),    32'h11);
        chk("ovr_valid", 32'(valid_o),   32'h1);
        chk("ovr_flag",  32'(overrun_o), 32'h1);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        tick(2);
        chk("ovr_valid_clr", 32'(valid_o),   32'h0);
        chk("ovr_sticky",    32'(overrun_o), 32'h1);
        ready_i = 1'b1;
        tick(5);

        // Reset during data bit 3 abandons the frame.
        rx_i = 1'b0;
        tick(C);
        for (int i = 0; i < 3; i++) begin
            rx_i = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(C);
        end
        rx_i = 1'b1;
        tick(C / 2);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_data",  32'(data_o),      32'h0);
        chk("mid_rst_valid", 32'(valid_o),     32'h0);
        chk("mid_rst_fe",    32'(frame_err_o), 32'h0);
        chk("mid_rst_ov",    32'(overrun_o),   32'h0);
        chk("mid_rst_busy",  32'(busy_o),      32'h0);
        rst = 1'b0;
        tick(10);
        chk("post_rst_busy", 32'(busy_o), 32'h0);
        fe0 = fe_cnt;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(10);
        chk("post_rst_ov", 32'(overrun_o),    32'h0);
        chk("post_rst_fe", 32'(fe_cnt - fe0), 32'h0);

        // Back-to-back frames with no idle gap.
        fe0 = fe_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(20);
        chk("b2b_ov", 32'(overrun_o),    32'h0);
        chk("b2b_fe", 32'(fe_cnt - fe0), 32'h0);

        tick(20);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brs_uart_rx.md
BRS_UART_RX -- requirements
Module: brs_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_i  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port data_o  output  8  received byte, stable while valid_o=1.
REQ-006 SHALL have port valid_o  output  1  holding register full.
REQ-007 SHALL have port ready_i  input  1  downstream consumer accepts byte when valid_o&ready_i.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port overrun_o  output  1  sticky flag: byte dropped because holding register full.
REQ-010 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: rxs=0 -> START, bit counter loaded with CLKS_PER_BIT/2 - 1 (integer division).
REQ-014 START: at counter zero, rxs=0 -> DATA with counter CLKS_PER_BIT-1 and bit index 0; rxs=1 -> IDLE (glitch rejected, no flags).
REQ-015 DATA: at each counter zero, sample rxs into shift register bit [index], reload counter; after index 7 -> STOP.
REQ-016 STOP: at counter zero, rxs=1 -> deliver byte (REQ-018) and go IDLE; rxs=0 -> pulse frame_err_o next cycle, discard byte, go WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rxs=1, then IDLE; a held-low line (break) SHALL produce exactly one frame_err_o pulse.
REQ-018 Delivery: if valid_o=0, or valid_o=1 and ready_i=1 in the same cycle, load data_o and set valid_o on the next edge; otherwise keep data_o unchanged and set overrun_o.
REQ-019 valid_o SHALL clear on the edge where valid_o&ready_i and no new byte is delivered.
REQ-020 Latency: valid_o rises exactly 1 cycle after the mid-stop sample cycle; mid-stop sample occurs 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after rx_i falls.
REQ-021 overrun_o SHALL remain set until rst; it SHALL not alter data_o.
REQ-022 Bit counter width SHALL be $clog2(CLKS_PER_BIT); no counter wrap beyond reload values.
REQ-023 A new start edge immediately after an accepted stop sample (no idle gap) SHALL be received correctly.

Reset
REQ-024 On rst=1 at a clk edge: state IDLE, data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, synchronizer flops=1, counters=0.
REQ-025 rst asserted mid-frame SHALL abandon the partial byte with no flag; reception resumes at the next falling edge after rst deasserts.

Structure
REQ-026 Package brs_pkg SHALL hold the state enum typedef and the CLKS_PER_BIT default constant.
REQ-027 The synchronizer SHALL be a separate sub-module brs_sync2 (2 flops, parameterized reset value).
REQ-028 All outputs SHALL be driven directly from flops.

Verification (bench uses CLKS_PER_BIT=16)
REQ-029 Send 0xA5, ready_i=1 -> data_o=0xA5, valid_o high exactly 1 cycle, frame_err_o=0, overrun_o=0.
REQ-030 rx_i low for 4 cycles then high -> no valid_o, no frame_err_o, busy_o returns low within 12 cycles.
REQ-031 Send 0x3C with stop bit 0, held low 40 further cycles -> single frame_err_o pulse, no valid_o, busy_o high until rx_i returns high.
REQ-032 Send 0x11 then 0x22, ready_i=0 -> data_o=0x11, valid_o=1, overrun_o=1; after ready_i pulse valid_o=0, overrun_o still 1.
REQ-033 Assert rst during bit 3 of a frame, release, send 0x5A -> all outputs 0 during reset, then data_o=0x5A delivered cleanly.
REQ-034 Back-to-back frames 0x00 and 0xFF with no idle gap, ready_i=1 -> two valid_o pulses, data 0x00 then 0xFF, no flags.
